// File: rtl/video_pkg.sv
// Shared types and helpers for the parametrised video timing generator.
// Axis timing is described as active/front-porch/sync/back-porch spans in order.
package video_pkg;

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        DRAIN
    } state_t;

    typedef struct packed {
        int unsigned active;
        int unsigned fp;
        int unsigned sync;
        int unsigned bp;
    } timing_t;

    function automatic int unsigned total(input timing_t t);
        return t.active + t.fp + t.sync + t.bp;
    endfunction

    // True when c lies in the half-open span [lo, lo+len).
    function automatic logic in_region(input int unsigned c,
                                       input int unsigned lo,
                                       input int unsigned len);
        return (c >= lo) && (c < lo + len);
    endfunction

endpackage

// File: rtl/video_axis_counter.sv
// One timing axis: wrapping position counter with terminal count and
// active/sync region decode derived from the axis timing struct.
module video_axis_counter
    import video_pkg::*;
#(
    parameter timing_t     T = '{active: 4, fp: 1, sync: 1, bp: 1},
    parameter int unsigned W = 3
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         i_en,
    input  logic         i_clr,
    output logic [W-1:0] o_cnt,
    output logic         o_tc,
    output logic         o_active,
    output logic         o_sync
);

    localparam int unsigned TOTAL = total(T);

    logic [W-1:0] r_cnt;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_cnt <= '0;
        end else if (i_clr) begin
            r_cnt <= '0;
        end else if (i_en) begin
            r_cnt <= o_tc ? '0 : r_cnt + W'(1);
        end
    end

    assign o_cnt    = r_cnt;
    assign o_tc     = (r_cnt == W'(TOTAL - 1));
    assign o_active = in_region(32'(r_cnt), 0, T.active);
    assign o_sync   = in_region(32'(r_cnt), T.active + T.fp, T.sync);

endmodule

// File: rtl/video_timing_gen.sv
// HDMI/DVI separate-sync video timing generator with a valid/ready pixel pull,
// registered outputs (one cycle behind the counters) and frame-boundary stop.
module video_timing_gen
    import video_pkg::*;
#(
    parameter int unsigned          DATA_W   = 36,
    parameter int unsigned          H_ACTIVE = 720,
    parameter int unsigned          H_FP     = 16,
    parameter int unsigned          H_SYNC   = 62,
    parameter int unsigned          H_BP     = 60,
    parameter int unsigned          V_ACTIVE = 480,
    parameter int unsigned          V_FP     = 9,
    parameter int unsigned          V_SYNC   = 6,
    parameter int unsigned          V_BP     = 30,
    parameter bit                   HS_POL   = 1'b0,
    parameter bit                   VS_POL   = 1'b0,
    parameter logic [DATA_W-1:0]    FILL     = '0
) (
    input  logic                                             clk,
    input  logic                                             rst,
    input  logic                                             en,
    input  logic [DATA_W-1:0]                                pix_data,
    input  logic                                             pix_valid,
    output logic                                             pix_ready,
    input  logic                                             underflow_clr,
    output logic [DATA_W-1:0]                                hdmi_data,
    output logic                                             hdmi_hsync,
    output logic                                             hdmi_vsync,
    output logic                                             hdmi_en,
    output logic                                             hdmi_clk,
    output logic [$clog2(H_ACTIVE+H_FP+H_SYNC+H_BP)-1:0]     x,
    output logic [$clog2(V_ACTIVE+V_FP+V_SYNC+V_BP)-1:0]     y,
    output logic                                             frame_start,
    output logic                                             underflow
);

    localparam timing_t     H_T = '{active: H_ACTIVE, fp: H_FP, sync: H_SYNC, bp: H_BP};
    localparam timing_t     V_T = '{active: V_ACTIVE, fp: V_FP, sync: V_SYNC, bp: V_BP};
    localparam int unsigned HW  = $clog2(total(H_T));
    localparam int unsigned VW  = $clog2(total(V_T));

    if (H_ACTIVE < 1 || H_FP < 1 || H_SYNC < 1 || H_BP < 1 ||
        V_ACTIVE < 1 || V_FP < 1 || V_SYNC < 1 || V_BP < 1) begin : g_bad_timing
        $error("video_timing_gen: every timing field must be >= 1");
    end

    state_t            r_state;
    state_t            w_next;
    logic              w_run;
    logic [HW-1:0]     w_h_cnt;
    logic [VW-1:0]     w_v_cnt;
    logic              w_h_tc, w_v_tc;
    logic              w_h_act, w_v_act;
    logic              w_h_sync, w_v_sync;

    logic [DATA_W-1:0] r_data;
    logic              r_de, r_hs, r_vs, r_fs, r_und;
    logic [HW-1:0]     r_x;
    logic [VW-1:0]     r_y;

    assign w_run = (r_state != IDLE);

    video_axis_counter #(
        .T (H_T),
        .W (HW)
    ) u_h_axis (
        .clk      (clk),
        .rst      (rst),
        .i_en     (w_run),
        .i_clr    (!w_run),
        .o_cnt    (w_h_cnt),
        .o_tc     (w_h_tc),
        .o_active (w_h_act),
        .o_sync   (w_h_sync)
    );

    video_axis_counter #(
        .T (V_T),
        .W (VW)
    ) u_v_axis (
        .clk      (clk),
        .rst      (rst),
        .i_en     (w_run && w_h_tc),
        .i_clr    (!w_run),
        .o_cnt    (w_v_cnt),
        .o_tc     (w_v_tc),
        .o_active (w_v_act),
        .o_sync   (w_v_sync)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    // DRAIN resumes on en before considering the frame-end exit.
    always_comb begin
        w_next = r_state;
        unique case (r_state)
            IDLE:    if (en) w_next = RUN;
            RUN:     if (!en) w_next = DRAIN;
            DRAIN: begin
                if (en) begin
                    w_next = RUN;
                end else if (w_h_tc && w_v_tc) begin
                    w_next = IDLE;
                end
            end
            default: w_next = IDLE;
        endcase
    end

    assign pix_ready = w_run && w_h_act && w_v_act;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_de   <= 1'b0;
            r_data <= '0;
            r_hs   <= ~HS_POL;
            r_vs   <= ~VS_POL;
            r_x    <= '0;
            r_y    <= '0;
            r_fs   <= 1'b0;
            r_und  <= 1'b0;
        end else begin
            r_de   <= pix_ready;
            r_data <= pix_ready ? (pix_valid ? pix_data : FILL) : '0;
            r_hs   <= (w_run && w_h_sync) ? HS_POL : ~HS_POL;
            r_vs   <= (w_run && w_v_sync) ? VS_POL : ~VS_POL;
            r_x    <= w_h_cnt;
            r_y    <= w_v_cnt;
            r_fs   <= w_run && (w_h_cnt == '0) && (w_v_cnt == '0);
            // A new underflow wins over a simultaneous clear.
            if (pix_ready && !pix_valid) begin
                r_und <= 1'b1;
            end else if (underflow_clr) begin
                r_und <= 1'b0;
            end
        end
    end

    assign hdmi_data   = r_data;
    assign hdmi_en     = r_de;
    assign hdmi_hsync  = r_hs;
    assign hdmi_vsync  = r_vs;
    assign x           = r_x;
    assign y           = r_y;
    assign frame_start = r_fs;
    assign underflow   = r_und;
    assign hdmi_clk    = clk;

endmodule

// File: tb/tb_video_timing_gen.sv
// Scoreboard bench for video_timing_gen with a 16x8 total raster (8x4 active).
// The driver predicts each cycle's outputs; a negedge monitor pops and compares.
module tb_video_timing_gen;

    localparam logic [15:0] FILLV = 16'hA5C3;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        en = 1'b0;
    logic        pix_valid = 1'b0;
    logic        underflow_clr = 1'b0;
    logic [15:0] pix_data = '0;
    logic        pix_ready;
    logic [15:0] hdmi_data;
    logic        hdmi_hsync, hdmi_vsync, hdmi_en, hdmi_clk;
    logic [3:0]  x;
    logic [2:0]  y;
    logic        frame_start, underflow;

    always #5 clk = ~clk;

    video_timing_gen #(
        .DATA_W   (16),
        .H_ACTIVE (8),
        .H_FP     (2),
        .H_SYNC   (3),
        .H_BP     (3),
        .V_ACTIVE (4),
        .V_FP     (1),
        .V_SYNC   (2),
        .V_BP     (1),
        .HS_POL   (1'b1),
        .VS_POL   (1'b0),
        .FILL     (FILLV)
    ) dut (
        .clk           (clk),
        .rst           (rst),
        .en            (en),
        .pix_data      (pix_data),
        .pix_valid     (pix_valid),
        .pix_ready     (pix_ready),
        .underflow_clr (underflow_clr),
        .hdmi_data     (hdmi_data),
        .hdmi_hsync    (hdmi_hsync),
        .hdmi_vsync    (hdmi_vsync),
        .hdmi_en       (hdmi_en),
        .hdmi_clk      (hdmi_clk),
        .x             (x),
        .y             (y),
        .frame_start   (frame_start),
        .underflow     (underflow)
    );

    typedef struct packed {
        logic        de;
        logic [15:0] data;
        logic        hs;
        logic        vs;
        logic [3:0]  x;
        logic [2:0]  y;
        logic        fs;
        logic        und;
    } out_t;

    typedef struct packed {
        out_t o;
        logic rdy;
    } exp_t;

    // hsync idles low (active-high), vsync idles high (active-low).
    localparam out_t RST_OUT = '{de: 1'b0, data: 16'h0, hs: 1'b0, vs: 1'b1,
                                 x: 4'h0, y: 3'h0, fs: 1'b0, und: 1'b0};

    exp_t        sbq[$];
    int          checks = 0;
    int          errors = 0;

    int          mst = 0;      // 0 idle, 1 run, 2 drain
    int          mt  = 0;      // raster position 0..127 = line*16 + column
    logic        mund = 1'b0;
    logic [15:0] dcnt = '0;
    out_t        cur_o = RST_OUT;
    out_t        nxt_o = RST_OUT;

    task automatic chk(input string n, input logic [31:0] a, input logic [31:0] e);
        checks++;
        if (a !== e) begin
            errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", n, a, e, $time);
        end
    endtask

    task automatic push_exp(input out_t o, input logic rdy);
        exp_t ex;
        ex.o   = o;
        ex.rdy = rdy;
        sbq.push_back(ex);
    endtask

    task automatic step(input logic e_i, input logic v_i, input logic c_i);
        int   h, v;
        logic run, act;
        @(posedge clk);
        #1;
        rst           = 1'b0;
        en            = e_i;
        pix_valid     = v_i;
        underflow_clr = c_i;
        pix_data      = dcnt;
        cur_o = nxt_o;
        run = (mst != 0);
        h   = mt % 16;
        v   = mt / 16;
        act = run && (h < 8) && (v < 4);
        push_exp(cur_o, act);
        nxt_o.de   = act;
        nxt_o.data = act ? (v_i ? dcnt : FILLV) : 16'h0;
        nxt_o.hs   = run && (h >= 10) && (h < 13);
        nxt_o.vs   = !(run && (v >= 5) && (v < 7));
        nxt_o.x    = 4'(h);
        nxt_o.y    = 3'(v);
        nxt_o.fs   = run && (mt == 0);
        if (act && !v_i) mund = 1'b1;
        else if (c_i)    mund = 1'b0;
        nxt_o.und = mund;
        if (act && v_i) dcnt = dcnt + 16'd1;
        case (mst)
            0: if (e_i) mst = 1;
            1: begin
                if (!e_i) mst = 2;
                mt = (mt + 1) % 128;
            end
            default: begin
                if (e_i) mst = 1;
                else if (mt == 127) mst = 0;
                mt = (mt + 1) % 128;
            end
        endcase
    endtask

    // Reset asserted between edges; outputs must settle before the next edge.
    task automatic rst_cycle();
        @(posedge clk);
        #1;
        rst = 1'b1;
        push_exp(RST_OUT, 1'b0);
        mst = 0; mt = 0; mund = 1'b0;
        cur_o = RST_OUT;
        nxt_o = RST_OUT;
        #1;
        chk("arst_de",    32'(hdmi_en),     32'(1'b0));
        chk("arst_data",  32'(hdmi_data),   32'(16'h0));
        chk("arst_hsync", 32'(hdmi_hsync),  32'(1'b0));
        chk("arst_vsync", 32'(hdmi_vsync),  32'(1'b1));
        chk("arst_xy",    32'({x, y}),      32'(7'h0));
        chk("arst_fs",    32'(frame_start), 32'(1'b0));
        chk("arst_und",   32'(underflow),   32'(1'b0));
        chk("arst_ready", 32'(pix_ready),   32'(1'b0));
    endtask

    task automatic run_to(input int target, input logic v_i, input logic c_i);
        for (int i = 0; i < 300 && mt != target; i++) step(1'b1, v_i, c_i);
        chk("run_to_bound", 32'(mt), 32'(target));
    endtask

    always @(negedge clk) begin
        exp_t e;
        if (sbq.size() > 0) begin
            e = sbq.pop_front();
            chk("pix_ready",   32'(pix_ready),   32'(e.rdy));
            chk("hdmi_en",     32'(hdmi_en),     32'(e.o.de));
            chk("hdmi_data",   32'(hdmi_data),   32'(e.o.data));
            chk("hdmi_hsync",  32'(hdmi_hsync),  32'(e.o.hs));
            chk("hdmi_vsync",  32'(hdmi_vsync),  32'(e.o.vs));
            chk("x",           32'(x),           32'(e.o.x));
            chk("y",           32'(y),           32'(e.o.y));
            chk("frame_start", 32'(frame_start), 32'(e.o.fs));
            chk("underflow",   32'(underflow),   32'(e.o.und));
            chk("hdmi_clk",    32'(hdmi_clk),    32'(clk));
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        rst_cycle();
        rst_cycle();
        // Idle with en low.
        repeat (50) step(1'b0, 1'b1, 1'b0);
        // Two full frames plus a little, continuous data.
        repeat (2 * 128 + 3) step(1'b1, 1'b1, 1'b0);
        // Underflow at pixel (3,1), then underflow+clear at (5,2), then clear alone.
        run_to(19, 1'b1, 1'b0);
        step(1'b1, 1'b0, 1'b0);
        run_to(37, 1'b1, 1'b0);
        step(1'b1, 1'b0, 1'b1);
        run_to(60, 1'b1, 1'b0);
        step(1'b1, 1'b1, 1'b1);
        repeat (5) step(1'b1, 1'b1, 1'b0);
        // Brief drain then resume mid-frame.
        run_to(20, 1'b1, 1'b0);
        repeat (3) step(1'b0, 1'b1, 1'b0);
        repeat (10) step(1'b1, 1'b1, 1'b0);
        // Stop at line 2: frame finishes, then idles.
        run_to(32, 1'b1, 1'b0);
        for (int i = 0; i < 300 && mst != 0; i++) step(1'b0, 1'b1, 1'b0);
        chk("drain_bound", 32'(mst), 32'(0));
        repeat (10) step(1'b0, 1'b1, 1'b0);
        repeat (140) step(1'b1, 1'b1, 1'b0);
        // Asynchronous reset mid-line.
        run_to(5, 1'b1, 1'b0);
        rst_cycle();
        repeat (5) step(1'b0, 1'b1, 1'b0);
        repeat (20) step(1'b1, 1'b1, 1'b0);
        @(negedge clk);
        #1;
        chk("scoreboard_empty", 32'(sbq.size()), 32'(0));
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/video_timing_gen.md
Name: video_timing_gen

Overview:
- Parametrised HDMI/DVI video timing generator for the RGB 4:4:4 separate-sync output path, driving the HDMI transmitter data/sync/DE pins.
- Generalises the fixed 720x480 generator: every horizontal and vertical timing field, the sync polarities and the data width are parameters.
- Adds pixel coordinates, a frame-start pulse, a valid/ready pull interface to the upstream pixel source, a sticky underflow flag and clean frame-boundary stop.

Parameters:
DATA_W, 36, pixel data width
H_ACTIVE, 720, active pixels per line
H_FP, 16, horizontal front porch (pixels)
H_SYNC, 62, hsync width (pixels)
H_BP, 60, horizontal back porch (pixels)
V_ACTIVE, 480, active lines per frame
V_FP, 9, vertical front porch (lines)
V_SYNC, 6, vsync width (lines)
V_BP, 30, vertical back porch (lines)
HS_POL, 0, hsync active level (1 = active-high)
VS_POL, 0, vsync active level (1 = active-high)
FILL, 0, pixel value output on underflow

Ports:
clk  in  1  pixel clock
rst  in  1  asynchronous, active-high reset
en  in  1  run request; sampled every cycle
pix_data  in  DATA_W  upstream pixel
pix_valid  in  1  upstream pixel available
pix_ready  out  1  pixel consumed this cycle when pix_valid is high
underflow_clr  in  1  clears underflow
hdmi_data  out  DATA_W  pixel to transmitter
hdmi_hsync  out  1  horizontal sync, polarity HS_POL
hdmi_vsync  out  1  vertical sync, polarity VS_POL
hdmi_en  out  1  data enable (DE)
hdmi_clk  out  1  equal to clk (pass-through)
x  out  $clog2(H_TOTAL)  column of the current output pixel
y  out  $clog2(V_TOTAL)  line of the current output pixel
frame_start  out  1  one-cycle pulse aligned with pixel (0,0)
underflow  out  1  sticky: pixel was missing in the active region

Behaviour:
- H_TOTAL = H_ACTIVE+H_FP+H_SYNC+H_BP; V_TOTAL = V_ACTIVE+V_FP+V_SYNC+V_BP. An elaboration-time assertion requires every field to be >= 1.
- Counters: h_cnt 0..H_TOTAL-1, wrapping to 0. v_cnt increments when h_cnt wraps and itself wraps at V_TOTAL-1. Both are unsigned, sized with $clog2 of the total.
- Regions per line: active [0,H_ACTIVE), then FP, then SYNC, then BP. Vertical regions use the same order, in lines.
- State machine states:
  - IDLE: counters held at 0, all outputs inactive. Moves to RUN on the first clock edge with en=1.
  - RUN: counters advance every cycle. Moves to DRAIN when en=0.
  - DRAIN: counters advance. Returns to RUN if en=1. Moves to IDLE after the cycle with h_cnt=H_TOTAL-1 and v_cnt=V_TOTAL-1; counters are then 0.
- pix_ready is combinational: high when the state is RUN or DRAIN and the counters are in both the horizontal and vertical active regions. It is independent of pix_valid.
- All hdmi_* outputs, x, y and frame_start are registered and represent the counters from the previous cycle (1-cycle latency).
  - hdmi_en = registered (active region).
  - hdmi_data = pix_data when pix_ready and pix_valid are both high, FILL when pix_ready is high and pix_valid is low, and 0 outside the active region.
- Sync outputs:
  - hsync is active while h_cnt is in the H SYNC region.
  - vsync is active for the whole line (from h_cnt=0) while v_cnt is in the V SYNC region.
  - In IDLE both sync outputs hold their inactive level (~POL).
- frame_start = registered (h_cnt==0 && v_cnt==0 && state is not IDLE).
- underflow is set, one cycle after the event, when pix_ready=1 and pix_valid=0. It is cleared by underflow_clr. A set and a clear in the same cycle leave it set.
- Reset values, applied immediately on async rst (including mid-frame):
  - state IDLE, counters 0
  - hdmi_en 0, hdmi_data 0, x 0, y 0, frame_start 0, underflow 0
  - hdmi_hsync = ~HS_POL, hdmi_vsync = ~VS_POL
  - pix_ready 0
- hdmi_clk = clk combinationally; it is never gated.

Decomposition:
- Package video_pkg holds:
  - the state enum typedef (IDLE, RUN, DRAIN)
  - a timing struct (active, fp, sync, bp)
  - helper functions total() and in_region()
- Sub-module video_axis_counter: one instance per axis. It provides a wrapping counter with en/clr inputs, a terminal-count output and region decode (active, sync).

Test Plan:
Use small parameters: H 8/2/3/3 (H_TOTAL 16), V 4/1/2/1 (V_TOTAL 8), one frame = 128 cycles.
1. Idle: reset, en=0 for 50 cycles -> hdmi_en=0, hsync and vsync at inactive level, pix_ready=0, frame_start=0.
2. Timing, en=1, pix_valid=1:
   - hdmi_en high for 8 cycles then low for 8, on lines 0-3 only.
   - hsync active on output cycles 11-13 of each line.
   - vsync active on lines 5-6.
   - frame_start every 128 cycles.
3. Data: pix_data increments on every handshake -> per frame hdmi_data reads 0..31 in order, with x 0..7 and y 0..3 aligned to hdmi_en.
4. Underflow:
   - pix_valid=0 on pixel (3,1) -> hdmi_data=FILL on that output cycle and underflow=1 from then on.
   - underflow_clr pulsed in the same cycle as a second underflow -> underflow stays 1.
   - underflow_clr alone -> underflow 0.
5. Stop: en=0 at line 2 -> frame finishes, IDLE at cycle 128, outputs inactive. en=1 again -> frame_start on the first output cycle of the new frame.
6. Polarity and reset: HS_POL=1, VS_POL=0 -> hsync idles at 0 and vsync idles at 1. Async rst mid-line -> all outputs reach reset values before the next clock edge.
